mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
Two-into-one memory arbiter between the CPU's instruction-fetch and data ports and a single unified memory bus with waitrequest. The CPU core raises a request per port and stalls until that port's ack. The arbiter serialises the requests onto the bus, one transaction at a time. Data requests win conflicts, and a streak limit guarantees that fetch cannot starve.

Parameters:
MAX_DATA_STREAK, 4, max consecutive data grants while instr_req is pending before instruction is forced (1..15)

Ports:
clk  input  1  rising-edge clock
reset  input  1  asynchronous, active-low reset
instr_req  input  1  fetch request, held until instr_ack
instr_address  input  32  fetch byte address
instr_ack  output  1  one-cycle pulse: fetch complete, instr_readdata valid
instr_readdata  output  32  fetched word, held until next fetch completes
data_req  input  1  data request, held until data_ack
data_write  input  1  1=write, 0=read (sampled with data_req)
data_address  input  32  data byte address
data_writedata  input  32  store data
data_byteenable  input  4  byte lanes
data_ack  output  1  one-cycle pulse: data transaction complete
data_readdata  output  32  load data, held until next data read completes
bus_address  output  32  word-aligned bus address
bus_read  output  1  bus read strobe
bus_write  output  1  bus write strobe
bus_writedata  output  32  bus write data
bus_byteenable  output  4  bus byte lanes (4'hF for fetches)
bus_waitrequest  input  1  1 = stall current transaction
bus_readdata  input  32  bus read data
misaligned  output  1  sticky: fetch issued with instr_address[1:0]!=0

Behaviour:
- Reset (reset=0, async): state IDLE; bus_read, bus_write, instr_ack, data_ack, misaligned = 0; bus_address, bus_writedata, instr_readdata, data_readdata = 0; bus_byteenable=0; streak counter=0. Reset mid-transaction drops strobes immediately; no ack is issued.
- States: IDLE, BUS_INSTR, BUS_DATA.
- IDLE, per rising edge:
  - A request is eligible if its req=1 and its ack is not high this cycle. A requester drops req in its ack cycle, and the ack-cycle req is ignored.
  - Both eligible: grant data unless streak == MAX_DATA_STREAK, in which case grant instr.
  - Only one eligible: grant it.
  - On grant, register bus_address={addr[31:2],2'b00}, writedata and byteenable. Assert bus_read or bus_write from the next cycle.
- BUS_x: strobes, address and writedata stay stable while bus_waitrequest=1.
  - At the edge where bus_waitrequest=0: deassert strobes, register bus_readdata into the port's readdata (reads only), pulse the port ack for exactly the next cycle, return to IDLE.
  - Minimum transaction = 1 strobe cycle, then ack, so back-to-back grants are spaced by 2 cycles.
- Streak counter:
  - Increments on each data grant made while instr_req=1.
  - Clears on an instr grant, and on a data grant made while instr_req=0.
  - Saturates at MAX_DATA_STREAK.
- Requests raised mid-transaction wait in IDLE. A req deasserted mid-transaction does not abort it; the ack still pulses.
- Fetch: bus_read only, byteenable 4'hF. If instr_address[1:0]!=0 at grant, set misaligned (sticky until reset); the aligned fetch still proceeds.
- data_readdata is unchanged by data writes. instr_readdata is unchanged by data transactions.
- Never assert bus_read and bus_write together. Never assert either in IDLE.

Test Plan:
- Reset then idle: reset low for 2 cycles mid-BUS_DATA write -> bus_write=0 immediately, no data_ack, all outputs 0 after release.
- Single fetch, waitrequest=0: instr_req, addr 0xBFC00000, bus_readdata 0x2402000A -> bus_read for 1 cycle at 0xBFC00000, then instr_ack 1 cycle, instr_readdata=0x2402000A.
- Wait states: data read at 0x1004, waitrequest high 3 cycles, bus_readdata 0xDEADBEEF -> bus_address/bus_read stable 4 cycles, data_ack once, data_readdata=0xDEADBEEF, bus_address=0x1004.
- Simultaneous: instr and data req in same IDLE cycle, data write 0x00000055 to 0x2000 with byteenable 4'b0001 -> data served first with bus_write and bus_byteenable=0001; instr fetch follows with byteenable=4'hF.
- Starvation: instr_req held while data_req re-asserted every IDLE, MAX_DATA_STREAK=4 -> exactly 4 data grants, then the instr grant, then the streak counter restarts.
- Misaligned fetch at 0x00000006 -> bus_address=0x00000004, misaligned=1 and it stays 1 through later aligned fetches until reset.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Two-into-one arbiter: instruction-fetch and data ports onto one memory bus with waitrequest.
// Data wins conflicts; a data streak limit forces a pending fetch through.
module mem_port_arbiter #(
   parameter int MAX_DATA_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        instr_req,
   input  logic [31:0] instr_address,
   output logic        instr_ack,
   output logic [31:0] instr_readdata,
   input  logic        data_req,
   input  logic        data_write,
   input  logic [31:0] data_address,
   input  logic [31:0] data_writedata,
   input  logic [3:0]  data_byteenable,
   output logic        data_ack,
   output logic [31:0] data_readdata,
   output logic [31:0] bus_address,
   output logic        bus_read,
   output logic        bus_write,
   output logic [31:0] bus_writedata,
   output logic [3:0]  bus_byteenable,
   input  logic        bus_waitrequest,
   input  logic [31:0] bus_readdata,
   output logic        misaligned,
   output logic [1:0]  dbg_state,
   output logic [3:0]  dbg_streak
);

   // Handshake: a port holds req until its one-cycle ack; the req seen during the ack cycle is ignored.
   typedef enum logic [1:0] {
      ST_IDLE      = 2'd0,
      ST_BUS_INSTR = 2'd1,
      ST_BUS_DATA  = 2'd2
   } state_t;

   localparam logic [3:0] STREAK_MAX = 4'(MAX_DATA_STREAK);

   state_t      r_state;
   logic [31:0] r_bus_address;
   logic        r_bus_read;
   logic        r_bus_write;
   logic [31:0] r_bus_writedata;
   logic [3:0]  r_bus_byteenable;
   logic        r_instr_ack;
   logic        r_data_ack;
   logic [31:0] r_instr_readdata;
   logic [31:0] r_data_readdata;
   logic        r_misaligned;
   logic [3:0]  r_streak;

   logic w_instr_elig;
   logic w_data_elig;
   logic w_streak_max;
   logic w_grant_instr;
   logic w_grant_data;
   logic [1:0] w_unused_data_lo;

   assign w_unused_data_lo = data_address[1:0];
   assign w_instr_elig  = instr_req & ~r_instr_ack;
   assign w_data_elig   = data_req & ~r_data_ack;
   assign w_streak_max  = (r_streak == STREAK_MAX);
   assign w_grant_instr = w_instr_elig & (~w_data_elig | w_streak_max);
   assign w_grant_data  = w_data_elig & ~w_grant_instr;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state          <= ST_IDLE;
         r_bus_address    <= 32'd0;
         r_bus_read       <= 1'b0;
         r_bus_write      <= 1'b0;
         r_bus_writedata  <= 32'd0;
         r_bus_byteenable <= 4'd0;
         r_instr_ack      <= 1'b0;
         r_data_ack       <= 1'b0;
         r_instr_readdata <= 32'd0;
         r_data_readdata  <= 32'd0;
         r_misaligned     <= 1'b0;
         r_streak         <= 4'd0;
      end else begin
         r_instr_ack <= 1'b0;
         r_data_ack  <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (w_grant_instr) begin
                  r_state          <= ST_BUS_INSTR;
                  r_bus_address    <= {instr_address[31:2], 2'b00};
                  r_bus_byteenable <= 4'hF;
                  r_bus_read       <= 1'b1;
                  r_streak         <= 4'd0;
                  if (instr_address[1:0] != 2'b00) r_misaligned <= 1'b1;
               end else if (w_grant_data) begin
                  r_state          <= ST_BUS_DATA;
                  r_bus_address    <= {data_address[31:2], 2'b00};
                  r_bus_writedata  <= data_writedata;
                  r_bus_byteenable <= data_byteenable;
                  r_bus_read       <= ~data_write;
                  r_bus_write      <= data_write;
                  // Only data wins that keep a fetch waiting count toward the limit.
                  if (instr_req) begin
                     if (!w_streak_max) r_streak <= r_streak + 4'd1;
                  end else begin
                     r_streak <= 4'd0;
                  end
               end
            end
            ST_BUS_INSTR: begin
               if (!bus_waitrequest) begin
                  r_bus_read       <= 1'b0;
                  r_instr_readdata <= bus_readdata;
                  r_instr_ack      <= 1'b1;
                  r_state          <= ST_IDLE;
               end
            end
            ST_BUS_DATA: begin
               if (!bus_waitrequest) begin
                  if (r_bus_read) r_data_readdata <= bus_readdata;
                  r_bus_read  <= 1'b0;
                  r_bus_write <= 1'b0;
                  r_data_ack  <= 1'b1;
                  r_state     <= ST_IDLE;
               end
            end
            default: begin
               r_bus_read  <= 1'b0;
               r_bus_write <= 1'b0;
               r_state     <= ST_IDLE;
            end
         endcase
      end
   end

   assign bus_address    = r_bus_address;
   assign bus_read       = r_bus_read;
   assign bus_write      = r_bus_write;
   assign bus_writedata  = r_bus_writedata;
   assign bus_byteenable = r_bus_byteenable;
   assign instr_ack      = r_instr_ack;
   assign data_ack       = r_data_ack;
   assign instr_readdata = r_instr_readdata;
   assign data_readdata  = r_data_readdata;
   assign misaligned     = r_misaligned;
   assign dbg_state      = r_state;
   assign dbg_streak     = r_streak;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: hand-computed expectations per cycle.
module tb_mem_port_arbiter;

   logic        clk;
   logic        reset;
   logic        instr_req;
   logic [31:0] instr_address;
   logic        instr_ack;
   logic [31:0] instr_readdata;
   logic        data_req;
   logic        data_write;
   logic [31:0] data_address;
   logic [31:0] data_writedata;
   logic [3:0]  data_byteenable;
   logic        data_ack;
   logic [31:0] data_readdata;
   logic [31:0] bus_address;
   logic        bus_read;
   logic        bus_write;
   logic [31:0] bus_writedata;
   logic [3:0]  bus_byteenable;
   logic        bus_waitrequest;
   logic [31:0] bus_readdata;
   logic        misaligned;
   logic [1:0]  dbg_state;
   logic [3:0]  dbg_streak;

   int n_tests = 0;
   int n_fail  = 0;
   int n_excl  = 0;

   localparam logic [31:0] S_IDLE  = 32'd0;
   localparam logic [31:0] S_INSTR = 32'd1;
   localparam logic [31:0] S_DATA  = 32'd2;

   mem_port_arbiter #(.MAX_DATA_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .instr_req(instr_req), .instr_address(instr_address),
      .instr_ack(instr_ack), .instr_readdata(instr_readdata),
      .data_req(data_req), .data_write(data_write), .data_address(data_address),
      .data_writedata(data_writedata), .data_byteenable(data_byteenable),
      .data_ack(data_ack), .data_readdata(data_readdata),
      .bus_address(bus_address), .bus_read(bus_read), .bus_write(bus_write),
      .bus_writedata(bus_writedata), .bus_byteenable(bus_byteenable),
      .bus_waitrequest(bus_waitrequest), .bus_readdata(bus_readdata),
      .misaligned(misaligned), .dbg_state(dbg_state), .dbg_streak(dbg_streak)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   always @(negedge clk) begin
      if (bus_read && bus_write) n_excl++;
      if ((bus_read || bus_write) && dbg_state == 2'd0) n_excl++;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_tests++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check_all_zero(input string tag);
      check({tag, "_rd"}, {31'd0, bus_read}, 32'd0);
      check({tag, "_wr"}, {31'd0, bus_write}, 32'd0);
      check({tag, "_iack"}, {31'd0, instr_ack}, 32'd0);
      check({tag, "_dack"}, {31'd0, data_ack}, 32'd0);
      check({tag, "_mis"}, {31'd0, misaligned}, 32'd0);
      check({tag, "_addr"}, bus_address, 32'd0);
      check({tag, "_wd"}, bus_writedata, 32'd0);
      check({tag, "_be"}, {28'd0, bus_byteenable}, 32'd0);
      check({tag, "_ird"}, instr_readdata, 32'd0);
      check({tag, "_drd"}, data_readdata, 32'd0);
      check({tag, "_st"}, {30'd0, dbg_state}, S_IDLE);
      check({tag, "_stk"}, {28'd0, dbg_streak}, 32'd0);
   endtask

   initial begin
      reset = 1'b0;
      instr_req = 1'b0; instr_address = 32'd0;
      data_req = 1'b0; data_write = 1'b0; data_address = 32'd0;
      data_writedata = 32'd0; data_byteenable = 4'd0;
      bus_waitrequest = 1'b0; bus_readdata = 32'd0;
      step(); step();
      check_all_zero("rst0");
      reset = 1'b1;
      step();
      check("idle_st", {30'd0, dbg_state}, S_IDLE);

      // Single fetch, no wait states
      bus_readdata = 32'h2402000A;
      instr_req = 1'b1; instr_address = 32'hBFC00000;
      step();
      check("f1_rd", {31'd0, bus_read}, 32'd1);
      check("f1_addr", bus_address, 32'hBFC00000);
      check("f1_be", {28'd0, bus_byteenable}, 32'hF);
      check("f1_iack0", {31'd0, instr_ack}, 32'd0);
      step();
      check("f1_iack", {31'd0, instr_ack}, 32'd1);
      check("f1_rd_off", {31'd0, bus_read}, 32'd0);
      check("f1_ird", instr_readdata, 32'h2402000A);
      instr_req = 1'b0;
      step();
      check("f1_iack_pulse", {31'd0, instr_ack}, 32'd0);
      check("f1_st", {30'd0, dbg_state}, S_IDLE);

      // Data read with three wait-state cycles
      bus_waitrequest = 1'b1; bus_readdata = 32'h0BADF00D;
      data_req = 1'b1; data_write = 1'b0; data_address = 32'h00001004;
      step();
      for (int c = 0; c < 4; c++) begin
         check("ws_rd", {31'd0, bus_read}, 32'd1);
         check("ws_addr", bus_address, 32'h00001004);
         check("ws_dack0", {31'd0, data_ack}, 32'd0);
         if (c == 3) begin
            bus_waitrequest = 1'b0; bus_readdata = 32'hDEADBEEF;
         end
         step();
      end
      check("ws_dack", {31'd0, data_ack}, 32'd1);
      check("ws_rd_off", {31'd0, bus_read}, 32'd0);
      check("ws_drd", data_readdata, 32'hDEADBEEF);
      check("ws_ird_kept", instr_readdata, 32'h2402000A);
      check("ws_addr_after", bus_address, 32'h00001004);
      data_req = 1'b0;
      step();
      check("ws_dack_pulse", {31'd0, data_ack}, 32'd0);
      check("ws_stk", {28'd0, dbg_streak}, 32'd0);

      // Simultaneous requests: data write first, then fetch
      bus_readdata = 32'h11112222;
      instr_req = 1'b1; instr_address = 32'h00003000;
      data_req = 1'b1; data_write = 1'b1; data_address = 32'h00002000;
      data_writedata = 32'h00000055; data_byteenable = 4'b0001;
      step();
      check("sim_st", {30'd0, dbg_state}, S_DATA);
      check("sim_wr", {31'd0, bus_write}, 32'd1);
      check("sim_rd", {31'd0, bus_read}, 32'd0);
      check("sim_be", {28'd0, bus_byteenable}, 32'h1);
      check("sim_wd", bus_writedata, 32'h00000055);
      check("sim_addr", bus_address, 32'h00002000);
      check("sim_stk", {28'd0, dbg_streak}, 32'd1);
      step();
      check("sim_dack", {31'd0, data_ack}, 32'd1);
      check("sim_drd_kept", data_readdata, 32'hDEADBEEF);
      data_req = 1'b0; data_write = 1'b0;
      step();
      check("sim_ist", {30'd0, dbg_state}, S_INSTR);
      check("sim_ird", {31'd0, bus_read}, 32'd1);
      check("sim_ibe", {28'd0, bus_byteenable}, 32'hF);
      check("sim_iaddr", bus_address, 32'h00003000);
      check("sim_stk_clr", {28'd0, dbg_streak}, 32'd0);
      step();
      check("sim_iack", {31'd0, instr_ack}, 32'd1);
      check("sim_ird_val", instr_readdata, 32'h11112222);
      instr_req = 1'b0;
      step();

      // Starvation guard: fetch withdrawn only in data ack cycles so data can win repeatedly
      instr_address = 32'h00004000;
      for (int k = 0; k < 4; k++) begin
         instr_req = 1'b1; data_req = 1'b1; data_address = 32'h00005000 + 32'(4 * k);
         step();
         check("stv_st", {30'd0, dbg_state}, S_DATA);
         check("stv_addr", bus_address, 32'h00005000 + 32'(4 * k));
         check("stv_stk", {28'd0, dbg_streak}, 32'(k + 1));
         step();
         check("stv_dack", {31'd0, data_ack}, 32'd1);
         instr_req = 1'b0; data_req = 1'b0;
         step();
      end
      instr_req = 1'b1; data_req = 1'b1; data_address = 32'h00005010;
      step();
      check("stv_forced_st", {30'd0, dbg_state}, S_INSTR);
      check("stv_forced_addr", bus_address, 32'h00004000);
      check("stv_stk_clr", {28'd0, dbg_streak}, 32'd0);
      step();
      check("stv_iack", {31'd0, instr_ack}, 32'd1);
      instr_req = 1'b0; data_req = 1'b0;
      step();
      instr_req = 1'b1; data_req = 1'b1;
      step();
      check("stv_restart_st", {30'd0, dbg_state}, S_DATA);
      check("stv_restart_stk", {28'd0, dbg_streak}, 32'd1);
      step();
      instr_req = 1'b0; data_req = 1'b0;
      step();

      // Misaligned fetch, then aligned fetch keeps the sticky flag
      check("mis_pre", {31'd0, misaligned}, 32'd0);
      instr_req = 1'b1; instr_address = 32'h00000006;
      step();
      check("mis_addr", bus_address, 32'h00000004);
      check("mis_flag", {31'd0, misaligned}, 32'd1);
      step();
      instr_req = 1'b0;
      step();
      instr_req = 1'b1; instr_address = 32'h00000008;
      step();
      check("mis_addr2", bus_address, 32'h00000008);
      step();
      check("mis_iack2", {31'd0, instr_ack}, 32'd1);
      check("mis_sticky", {31'd0, misaligned}, 32'd1);
      instr_req = 1'b0;
      step();

      // Reset in the middle of a stalled data write
      bus_waitrequest = 1'b1;
      data_req = 1'b1; data_write = 1'b1; data_address = 32'h00007000;
      data_writedata = 32'hCAFE0001; data_byteenable = 4'hC;
      step();
      check("rw_wr", {31'd0, bus_write}, 32'd1);
      reset = 1'b0;
      #1;
      check("rw_wr_drop", {31'd0, bus_write}, 32'd0);
      data_req = 1'b0; data_write = 1'b0; bus_waitrequest = 1'b0;
      step();
      check("rw_dack_a", {31'd0, data_ack}, 32'd0);
      step();
      reset = 1'b1;
      step();
      check("rw_dack_b", {31'd0, data_ack}, 32'd0);
      check_all_zero("rst1");

      check("bus_exclusive", 32'(n_excl), 32'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
